// File: rtl/trace_pkg.sv
// Shared types for the retire-trace capture path: entry kinds and the entry record.
// No logic here; widths are fixed by the core's trace port.
// Consumers and producers import this package to agree on the entry layout.
package trace_pkg;

    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TAG_W  = 9;
    localparam int TRACE_SEQ_W  = 16;

    typedef enum logic [1:0] {
        REG  = 2'b01,
        MEMW = 2'b10,
        MEMR = 2'b11
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [TRACE_TAG_W-1:0]  tag;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_SEQ_W-1:0]  seq;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace entry storage: two write ports (slot 1 follows slot 0), one first-word-fall-through read port.
// Latency: a write at edge T is readable right after T; read data is a mux off the read pointer.
// Backpressure: none internally; the caller must only push what fits and only pop when level is non-zero.
module trace_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int W     = 59
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push0,
    input  logic                       push1,
    input  logic [W-1:0]               din0,
    input  logic [W-1:0]               din1,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr_p1;
    logic [AW-1:0] push_cnt;

    assign wptr_p1  = wptr + AW'(1);
    assign push_cnt = AW'(push0) + AW'(push1);
    assign dout     = mem[rptr];

    // Storage array: slot 0 lands at wptr, slot 1 at the next location.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push0) mem[wptr]    <= din0;
            if (push1) mem[wptr_p1] <= din1;
        end
    end

    // Pointers and occupancy; clear wipes everything, pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + push_cnt;
            if (pop) rptr <= rptr + AW'(1);
            level <= level + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Retire-trace capture: turns core write-back and data-memory activity into sequence-numbered FIFO entries.
// Latency: an event sampled at edge T is presented on out_* right after T when the FIFO was empty.
// Backpressure: never stalls the core; a cycle whose events do not all fit is dropped whole and counted.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [8:0]               addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [8:0]               out_tag,
    output logic [DATA_W-1:0]        out_data,
    output logic [15:0]              out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 2 + TRACE_TAG_W + DATA_W + TRACE_SEQ_W;

    logic                  mem_ev;
    logic                  reg_ev;
    trace_kind_e           mem_kind;
    logic [1:0]            need;
    logic [AW:0]           free;
    logic                  fits;
    logic                  push0;
    logic                  push1;
    logic                  pop;
    logic [15:0]           seq;
    logic [15:0]           seq_p1;
    logic [16:0]           drop_sum;
    logic [ENTRY_W-1:0]    mem_entry;
    logic [ENTRY_W-1:0]    reg_entry;
    logic [ENTRY_W-1:0]    slot0;
    logic [ENTRY_W-1:0]    slot1;
    logic [ENTRY_W-1:0]    head;

    // A store wins over a load when both strobes are up; x0 writes are invisible.
    assign mem_ev   = wr | rd;
    assign mem_kind = wr ? MEMW : MEMR;
    assign reg_ev   = reg_write_sig && (reg_num != 5'd0);
    assign need     = 2'(mem_ev) + 2'(reg_ev);

    // Space is judged on the registered level only, so a same-cycle pop never makes room.
    assign free = (AW+1)'(DEPTH) - level;
    assign fits = ((AW+1)'(need) <= free);

    assign seq_p1 = seq + 16'd1;

    // The memory entry always takes the first seq; the register entry takes whichever slot is next.
    assign mem_entry = {mem_kind, addr, (wr ? wr_data : rd_data), seq};
    assign reg_entry = {REG, {4'd0, reg_num}, reg_data, (mem_ev ? seq_p1 : seq)};
    assign slot0     = mem_ev ? mem_entry : reg_entry;
    assign slot1     = reg_entry;

    assign push0 = !clear && fits && (need != 2'd0);
    assign push1 = !clear && fits && (need == 2'd2);
    assign pop   = !clear && out_valid && out_ready;

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push0 (push0),
        .push1 (push1),
        .din0  (slot0),
        .din1  (slot1),
        .pop   (pop),
        .dout  (head),
        .level (level)
    );

    assign out_valid = (level != '0);
    assign out_kind  = head[ENTRY_W-1 -: 2];
    assign out_tag   = head[ENTRY_W-3 -: TRACE_TAG_W];
    assign out_data  = head[TRACE_SEQ_W +: DATA_W];
    assign out_seq   = head[TRACE_SEQ_W-1:0];

    assign drop_sum = {1'b0, drop_count} + 17'(need);

    // Sequence numbers advance for every event, dropped or not; drops set the sticky flag and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            seq <= seq + 16'(need);
            if (!fits) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: store, load+write-back, x0 filter, overflow, full+pop, clear, async reset.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [8:0]  out_tag;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    wb_trace_buffer #(.DEPTH(16), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_kind      (out_kind),
        .out_tag       (out_tag),
        .out_data      (out_data),
        .out_seq       (out_seq),
        .level         (level),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear         = 1'b0;
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = 32'd0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = 9'd0;
        wr_data       = 32'd0;
        rd_data       = 32'd0;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] k, input logic [8:0] t,
                            input logic [31:0] d, input logic [15:0] s);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".kind"},  64'(out_kind),  64'(k));
        chk({tag, ".tag"},   64'(out_tag),   64'(t));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".seq"},   64'(out_seq),   64'(s));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        idle();
        out_ready = 1'b0;
        reset     = 1'b1;
        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.level", 64'(level), 64'd0);
        chk("rst.ovf",   64'(overflow), 64'd0);
        chk("rst.drop",  64'(drop_count), 64'd0);
        reset = 1'b0;
        step();

        // Single store
        wr = 1'b1; addr = 9'h004; wr_data = 32'hDEADBEEF;
        step();
        idle();
        chk("store.level", 64'(level), 64'd1);
        chk_head("store", MEMW, 9'h004, 32'hDEADBEEF, 16'd0);
        pop_one();
        chk("store.drained", 64'(level), 64'd0);

        // Load with write-back, after a clear so numbering restarts
        clear = 1'b1;
        step();
        idle();
        rd = 1'b1; addr = 9'h010; rd_data = 32'h55;
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h55;
        step();
        idle();
        chk("load.level", 64'(level), 64'd2);
        chk_head("load.mem", MEMR, 9'h010, 32'h55, 16'd0);
        pop_one();
        chk_head("load.reg", REG, 9'h007, 32'h55, 16'd1);
        pop_one();
        chk("load.drained", 64'(level), 64'd0);

        // x0 writes never produce entries or consume numbers
        reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h1234;
        for (int i = 0; i < 5; i++) step();
        idle();
        chk("x0.level", 64'(level), 64'd0);
        chk("x0.valid", 64'(out_valid), 64'd0);
        wr = 1'b1; addr = 9'h1FF; wr_data = 32'hA5A5A5A5;
        step();
        idle();
        chk_head("x0.next", MEMW, 9'h1FF, 32'hA5A5A5A5, 16'd2);
        pop_one();

        // Overflow: fill to 15, then a two-event cycle is dropped whole
        clear = 1'b1;
        step();
        idle();
        for (int i = 0; i < 15; i++) begin
            wr = 1'b1; addr = 9'(i); wr_data = 32'(i);
            step();
        end
        idle();
        chk("fill.level", 64'(level), 64'd15);
        rd = 1'b1; addr = 9'h020; rd_data = 32'h99;
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h99;
        step();
        idle();
        chk("ovf.level", 64'(level), 64'd15);
        chk("ovf.flag",  64'(overflow), 64'd1);
        chk("ovf.drop",  64'(drop_count), 64'd2);
        wr = 1'b1; addr = 9'h017; wr_data = 32'h17;
        step();
        idle();
        chk("ovf.accept.level", 64'(level), 64'd16);

        // Full with simultaneous pop: pop honoured, push refused
        out_ready = 1'b1;
        wr = 1'b1; addr = 9'h018; wr_data = 32'h18;
        step();
        idle();
        out_ready = 1'b0;
        chk("fullpop.level", 64'(level), 64'd15);
        chk("fullpop.drop",  64'(drop_count), 64'd3);
        chk("fullpop.flag",  64'(overflow), 64'd1);

        // Remaining entries: seq 1..14 then the gap to 17
        for (int i = 1; i <= 15; i++) begin
            if (i < 15) chk_head("drain", MEMW, 9'(i), 32'(i), 16'(i));
            else        chk_head("drain.gap", MEMW, 9'h017, 32'h17, 16'd17);
            pop_one();
        end
        chk("drain.level", 64'(level), 64'd0);
        chk("drain.valid", 64'(out_valid), 64'd0);

        // Clear mid-drain ignores same-cycle events and pops
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; addr = 9'(8'h40 + i); wr_data = 32'(i + 100);
            step();
        end
        idle();
        chk_head("pre.clear", MEMW, 9'h040, 32'd100, 16'd19);
        pop_one();
        chk("pre.clear.level", 64'(level), 64'd2);
        clear = 1'b1; out_ready = 1'b1; wr = 1'b1; addr = 9'h055; wr_data = 32'h55;
        step();
        idle();
        out_ready = 1'b0;
        chk("clear.level", 64'(level), 64'd0);
        chk("clear.valid", 64'(out_valid), 64'd0);
        chk("clear.ovf",   64'(overflow), 64'd0);
        chk("clear.drop",  64'(drop_count), 64'd0);
        wr = 1'b1; addr = 9'h066; wr_data = 32'h66;
        step();
        idle();
        chk_head("clear.restart", MEMW, 9'h066, 32'h66, 16'd0);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("areset.valid", 64'(out_valid), 64'd0);
        chk("areset.level", 64'(level), 64'd0);
        #1;
        reset = 1'b0;
        step();
        reg_write_sig = 1'b1; reg_num = 5'd31; reg_data = 32'hCAFEF00D;
        step();
        idle();
        chk_head("after.reset", REG, 9'h01F, 32'hCAFEF00D, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
